// File: rtl/stream_pkg.sv
// Shared definitions for kernel stream ports: the default word width,
// the stream word type and a helper that extracts the end-of-transfer flag.
package stream_pkg;

   localparam int DATA_WIDTH_DEFAULT = 33;

   // Stream word: 32 payload bits plus the end-of-transfer flag in the MSB
   typedef logic [DATA_WIDTH_DEFAULT-1:0] stream_word_t;

   // Returns the end-of-transfer (close token) flag of a stream word
   function automatic logic eot_bit(input stream_word_t word);
      return word[DATA_WIDTH_DEFAULT-1];
   endfunction

endpackage

// File: rtl/eot_stream_fifo.sv
// Show-ahead stream FIFO placed between kernel stream ports. It counts the
// close tokens (MSB of each word) it holds and latches sticky flags when a
// neighbour writes while full or reads while empty.
module eot_stream_fifo
   import stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int DEPTH      = 4,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   input  logic                  if_write,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   input  logic                  if_read,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  eot_pending,
   output logic                  overflow_err,
   output logic                  underflow_err
);

   localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   eot_cnt;
   logic                  rst_done;
   logic                  wr_en;
   logic                  rd_en;
   logic                  wr_eot;
   logic                  rd_eot;

   // Handshake flags come from registered state only, so neither if_write
   // nor if_read can loop back combinationally into the neighbouring kernel.
   assign if_full_n  = rst_done && (count != FULL_COUNT);
   assign if_empty_n = (count != '0);

   assign wr_en  = if_write && if_full_n;
   assign rd_en  = if_read && if_empty_n;
   assign wr_eot = wr_en && if_din[DATA_WIDTH-1];
   assign rd_eot = rd_en && if_dout[DATA_WIDTH-1];

   // Head of queue is always visible; it is stale whenever if_empty_n is low
   assign if_dout     = mem[rd_ptr];
   assign eot_pending = (eot_cnt != '0);

   // Holds off writes until one full clock has passed after reset release
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rst_done <= 1'b0;
      end else begin
         rst_done <= 1'b1;
      end
   end

   // Storage array, wiped on reset so the head reads zero until first write
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_ptr] <= if_din;
      end
   end

   // Read and write pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Occupancy: a simultaneous accepted push and pop leaves it unchanged
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         count <= '0;
      end else begin
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Number of close tokens currently buffered
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         eot_cnt <= '0;
      end else begin
         case ({wr_eot, rd_eot})
            2'b10:   eot_cnt <= eot_cnt + 1'b1;
            2'b01:   eot_cnt <= eot_cnt - 1'b1;
            default: eot_cnt <= eot_cnt;
         endcase
      end
   end

   // Sticky protocol-misuse flags, ignored while the block is still waking up
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         if (if_write && !if_full_n && rst_done) begin
            overflow_err <= 1'b1;
         end
         if (if_read && !if_empty_n && rst_done) begin
            underflow_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_eot_stream_fifo.sv
// Bench for eot_stream_fifo: a queue-based model of the stream buffer is
// compared against the design on every falling edge, with hand-computed
// literal expectations at the interesting points of each directed scenario.
module tb_eot_stream_fifo;
   import stream_pkg::*;

   localparam int DEPTH     = 4;
   localparam int N_STREAM  = 1000;
   localparam int MAX_CYCLE = 20000;

   logic         ap_clk;
   logic         ap_rst_n;
   stream_word_t if_din;
   logic         if_full_n;
   logic         if_write;
   stream_word_t if_dout;
   logic         if_empty_n;
   logic         if_read;
   logic [2:0]   count;
   logic         eot_pending;
   logic         overflow_err;
   logic         underflow_err;

   int checks = 0;
   int errors = 0;

   // Model state
   stream_word_t model_q[$];
   logic         model_ready = 1'b0;
   logic         model_ovf   = 1'b0;
   logic         model_udf   = 1'b0;
   logic         last_wr_acc = 1'b0;
   logic         compare_on  = 1'b0;
   logic         stream_on   = 1'b0;
   int           rx_idx      = 0;
   int           max_count   = 0;

   eot_stream_fifo #(.DATA_WIDTH(33), .DEPTH(DEPTH)) dut (
      .ap_clk        (ap_clk),
      .ap_rst_n      (ap_rst_n),
      .if_din        (if_din),
      .if_full_n     (if_full_n),
      .if_write      (if_write),
      .if_dout       (if_dout),
      .if_empty_n    (if_empty_n),
      .if_read       (if_read),
      .count         (count),
      .eot_pending   (eot_pending),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err)
   );

   // 10 ns clock
   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int model_eot_count();
      int n = 0;
      foreach (model_q[i]) begin
         if (eot_bit(model_q[i])) n++;
      end
      return n;
   endfunction

   function automatic stream_word_t stream_word(input int idx);
      logic        eot;
      logic [31:0] payload;
      eot     = ((idx % 7) == 6);
      payload = 32'(idx) ^ 32'hA5C3_0000;
      return {eot, payload};
   endfunction

   // Behavioural model: a bounded queue plus the wake-up and error rules
   always @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         model_q.delete();
         model_ready = 1'b0;
         model_ovf   = 1'b0;
         model_udf   = 1'b0;
         last_wr_acc = 1'b0;
      end else begin
         logic can_wr;
         logic can_rd;
         logic wr_ok;
         logic rd_ok;
         can_wr = model_ready && (model_q.size() < DEPTH);
         can_rd = (model_q.size() > 0);
         wr_ok  = if_write && can_wr;
         rd_ok  = if_read && can_rd;
         if (if_write && !can_wr && model_ready) model_ovf = 1'b1;
         if (if_read && !can_rd && model_ready)  model_udf = 1'b1;
         if (rd_ok) begin
            if (stream_on) begin
               check_output("stream_order", if_dout, stream_word(rx_idx));
               rx_idx++;
            end
            void'(model_q.pop_front());
         end
         if (wr_ok) model_q.push_back(if_din);
         last_wr_acc = wr_ok;
         model_ready = 1'b1;
      end
   end

   // Compare process: every falling edge, all outputs against the model
   always @(negedge ap_clk) begin
      if (compare_on) begin
         check_output("cmp_full_n", if_full_n, model_ready && (model_q.size() < DEPTH));
         check_output("cmp_empty_n", if_empty_n, model_q.size() > 0);
         check_output("cmp_count", count, model_q.size());
         check_output("cmp_eot_pending", eot_pending, model_eot_count() != 0);
         check_output("cmp_overflow", overflow_err, model_ovf);
         check_output("cmp_underflow", underflow_err, model_udf);
         if (model_q.size() > 0) check_output("cmp_dout", if_dout, model_q[0]);
         if (int'(count) > max_count) max_count = int'(count);
      end
   end

   // One clock of stimulus; returns just after the rising edge
   task automatic apply_stimulus(input logic wr, input logic rd, input stream_word_t d);
      if_write = wr;
      if_read  = rd;
      if_din   = d;
      @(posedge ap_clk);
      #1;
      if_write = 1'b0;
      if_read  = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_full_n"}, if_full_n, 0);
      check_output({tag, "_empty_n"}, if_empty_n, 0);
      check_output({tag, "_dout"}, if_dout, 0);
      check_output({tag, "_count"}, count, 0);
      check_output({tag, "_eot"}, eot_pending, 0);
      check_output({tag, "_ovf"}, overflow_err, 0);
      check_output({tag, "_udf"}, underflow_err, 0);
   endtask

   initial begin
      stream_word_t floats [4];
      stream_word_t fill [4];
      logic wr;
      logic rd;
      int   sent;
      floats = '{33'h0_0000_0000, 33'h0_3F80_0000, 33'h0_4000_0000, 33'h0_4040_0000};
      fill   = '{33'h0_1111_1111, 33'h1_2222_2222, 33'h0_3333_3333, 33'h1_4444_4444};

      ap_rst_n = 1'b0;
      if_write = 1'b0;
      if_read  = 1'b0;
      if_din   = '0;

      // Reset and idle
      repeat (2) @(posedge ap_clk);
      #1;
      compare_on = 1'b1;
      check_reset_outputs("in_reset");
      #1 ap_rst_n = 1'b1;
      #1 check_output("full_n_first_cycle", if_full_n, 0);
      @(posedge ap_clk);
      #1 check_output("full_n_after_wake", if_full_n, 1);

      // Fill with shortreal bit patterns, then overflow
      for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, floats[i]);
      check_output("fill_count", count, 4);
      check_output("fill_full_n", if_full_n, 0);
      check_output("fill_ovf_clear", overflow_err, 0);
      apply_stimulus(1'b1, 1'b0, 33'h0_4080_0000);
      check_output("ovf_set", overflow_err, 1);
      check_output("ovf_count", count, 4);
      for (int i = 0; i < 4; i++) begin
         check_output($sformatf("float_read_%0d", i), if_dout, floats[i]);
         apply_stimulus(1'b0, 1'b1, '0);
      end
      check_output("drained_count", count, 0);
      check_output("drained_empty_n", if_empty_n, 0);

      // Asynchronous reset in the middle of traffic
      apply_stimulus(1'b1, 1'b0, 33'h0_0000_00AA);
      apply_stimulus(1'b1, 1'b1, 33'h1_0000_00BB);
      apply_stimulus(1'b1, 1'b0, 33'h0_0000_00CC);
      check_output("pre_reset_count", count, 2);
      #2 ap_rst_n = 1'b0;
      #1 check_reset_outputs("mid_reset");
      @(posedge ap_clk);
      #1 ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1 check_output("full_n_after_reset2", if_full_n, 1);

      // Close token tracking
      apply_stimulus(1'b1, 1'b0, 33'h0_4080_0000);
      check_output("eot_none_yet", eot_pending, 0);
      apply_stimulus(1'b1, 1'b0, 33'h1_0000_0000);
      check_output("eot_stored", eot_pending, 1);
      check_output("eot_head", if_dout, 33'h0_4080_0000);
      apply_stimulus(1'b0, 1'b1, '0);
      check_output("eot_after_data_read", eot_pending, 1);
      check_output("eot_token_head", if_dout, 33'h1_0000_0000);
      apply_stimulus(1'b0, 1'b1, '0);
      check_output("eot_after_token_read", eot_pending, 0);
      check_output("eot_count_zero", count, 0);

      // Full FIFO with write and read together
      for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, fill[i]);
      check_output("full_both_pre_ovf", overflow_err, 0);
      apply_stimulus(1'b1, 1'b1, 33'h0_DEAD_BEEF);
      check_output("full_both_count", count, 3);
      check_output("full_both_ovf", overflow_err, 1);
      for (int i = 1; i < 4; i++) begin
         check_output($sformatf("full_both_read_%0d", i), if_dout, fill[i]);
         apply_stimulus(1'b0, 1'b1, '0);
      end
      check_output("full_both_drained", if_empty_n, 0);

      // Empty FIFO with write and read together
      check_output("empty_both_pre_udf", underflow_err, 0);
      apply_stimulus(1'b1, 1'b1, 33'h1_CAFE_F00D);
      check_output("empty_both_count", count, 1);
      check_output("empty_both_empty_n", if_empty_n, 1);
      check_output("empty_both_dout", if_dout, 33'h1_CAFE_F00D);
      check_output("empty_both_udf", underflow_err, 1);
      apply_stimulus(1'b0, 1'b1, '0);

      // Random throttled streaming
      stream_on = 1'b1;
      sent      = 0;
      max_count = 0;
      for (int cyc = 0; cyc < MAX_CYCLE && rx_idx < N_STREAM; cyc++) begin
         wr = (sent < N_STREAM) && ($urandom_range(0, 99) < 60);
         rd = ($urandom_range(0, 99) < 55);
         apply_stimulus(wr, rd, stream_word(sent));
         if (last_wr_acc) sent++;
      end
      stream_on = 1'b0;
      check_output("stream_sent", sent, N_STREAM);
      check_output("stream_received", rx_idx, N_STREAM);
      check_output("stream_max_count_ok", max_count <= DEPTH, 1);

      @(negedge ap_clk);
      compare_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/eot_stream_fifo.md
Name: eot_stream_fifo

Overview:
- Producer/consumer buffer that sits on the other end of the kernel stream ports.
- The write side accepts din/full_n/write from an upstream kernel output; the read side presents dout/empty_n/read to a downstream kernel input.
- The MSB of every word is the end-of-transfer (EoT, close-token) flag. The FIFO tracks buffered close tokens and flags protocol misuse.
- Used between VecAdd-style kernels and as the stream model in RTL benches.

Parameters:
- DATA_WIDTH, 33, word width including EoT flag at bit DATA_WIDTH-1.
- DEPTH, 4, number of entries; power of two, >= 2.
- ADDR_WIDTH, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- ap_clk  in  1  single clock, all state on rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- if_din  in  DATA_WIDTH  write data, [DATA_WIDTH-1] = EoT.
- if_full_n  out  1  high when a write can be accepted.
- if_write  in  1  write request.
- if_dout  out  DATA_WIDTH  head-of-queue data (show-ahead).
- if_empty_n  out  1  high when if_dout holds a valid word.
- if_read  in  1  read request; pops the word shown on if_dout.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- eot_pending  out  1  at least one close token is buffered.
- overflow_err  out  1  sticky; write attempted while if_full_n low.
- underflow_err  out  1  sticky; read attempted while if_empty_n low.

Behaviour:
- Reset (async assert, release on clock edge): pointers, count, eot counter, storage array, both error flags and rst_done cleared to 0.
- rst_done sets on the first rising edge with ap_rst_n high.
- Outputs during and just after reset: if_full_n=0, if_empty_n=0, if_dout=0, count=0, eot_pending=0. if_full_n rises one cycle after reset release.
- if_full_n = rst_done && (count != DEPTH).
- if_empty_n = (count != 0).
- Both are decoded from registered state only; there is no combinational path from if_write or if_read.
- Accepted write: wr_en = if_write && if_full_n. Stores if_din at wr_ptr; wr_ptr advances modulo DEPTH.
- Accepted read: rd_en = if_read && if_empty_n. rd_ptr advances modulo DEPTH.
- if_dout = mem[rd_ptr] combinationally. Valid whenever if_empty_n=1; otherwise shows the stale entry, and consumers must ignore it.
- Latency: a write into an empty FIFO raises if_empty_n on the following cycle. There is no fall-through.
- count: +1 on wr_en only, -1 on rd_en only, unchanged when both fire.
- Simultaneous write and read:
  - When full: the read is accepted and the write is rejected (if_full_n=0 that cycle). This sets overflow_err.
  - When empty: the write is accepted and the read is rejected. This sets underflow_err.
  - Otherwise both are accepted and count is held.
- EoT tracking:
  - eot_cnt (ADDR_WIDTH+1 bits) +1 on wr_en with if_din[MSB]=1.
  - eot_cnt -1 on rd_en with if_dout[MSB]=1.
  - Both in the same cycle leave it unchanged.
  - eot_pending = (eot_cnt != 0).
- Error flags:
  - overflow_err sets on if_write && !if_full_n && rst_done.
  - underflow_err sets on if_read && !if_empty_n && rst_done.
  - Both clear only on reset.
- The FIFO never alters data. EoT words are stored and delivered like any other word, in order.
- Reset mid-operation: all contents are discarded immediately (async). The outputs follow the reset values above.

Decomposition:
- Shared package stream_pkg:
  - DATA_WIDTH_DEFAULT=33
  - function eot_bit(word) returning the MSB
  - typedef for the stream word (logic [32:0])
- Storage array, pointers and counters stay inline in one module; no sub-module is warranted.

Test Plan:
- Reset, then hold idle -> if_full_n=0 during reset and the first cycle after release, then 1; if_empty_n=0; count=0; no error flags.
- DEPTH=4:
  - Write shortreal bits of 0.0,1.0,2.0,3.0 (EoT=0) on consecutive cycles -> count=4 and if_full_n=0 after the 4th.
  - A 5th write attempt sets overflow_err and is dropped.
  - Four reads then return 0x00000000, 0x3F800000, 0x40000000, 0x40400000 in order.
- Write 4.0, then {1'b1,32'h0} -> eot_pending=1 once the close token is stored. The read of 4.0 keeps it 1; the read of the close token drops it to 0 on the next cycle.
- Full FIFO with if_write and if_read both high -> one pop, count=3, write rejected, overflow_err=1.
- Empty FIFO with both high -> write accepted, count=1, if_dout valid next cycle, underflow_err=1.
- Random throttled streaming of 1000 words (random if_write/if_read) -> output sequence identical to input, count never above 4.
- Async reset asserted mid-stream -> outputs at reset values within the same cycle.
